// File: rtl/multiply_by_two_n.sv
// Sequential unsigned shift-and-add multiplier: WIDTH x WIDTH -> 2*WIDTH product.
// Latency: accept edge is edge 0, out_valid rises after edge WIDTH; WIDTH+2 cycles per op back-to-back.
// Backpressure: in_ready low in CALC/DONE; product and out_valid held in DONE until out_ready.
//
// Ports:
//   clk        single clock, rising edge
//   rstN       synchronous active-low reset
//   in_valid   operand pair valid          in_ready  block can accept operands
//   a, b       WIDTH-bit unsigned operands
//   out_valid  product valid               out_ready consumer accepts product
//   product    2*WIDTH-bit unsigned a*b (qualified by out_valid, retained in IDLE)
//   busy       iteration in progress (state CALC)

module multiply_by_two_n #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]   count;

  // Partial-product sum for the current CALC edge. The final iteration's value
  // is also the product, so it is loaded straight into the output register.
  logic [PW-1:0]   acc_next;

  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
      product   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            count  <= '0;
            state  <= CALC;
          end
        end

        CALC: begin
          // Fixed WIDTH iterations; zero operands are not short-circuited so
          // latency is independent of the data.
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (count == LAST_COUNT) begin
            state     <= DONE;
            product   <= acc_next;
            out_valid <= 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Decoded from the state register only; held low while reset is asserted so
  // no operand pair can be taken on a reset edge.
  assign in_ready = rstN && (state == IDLE);
  assign busy     = (state == CALC);

endmodule

// File: tb/tb_multiply_by_two_n.sv
module tb_multiply_by_two_n;

  logic        clk;
  logic        rstN;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int npass;
  int ntotal;

  multiply_by_two_n #(.WIDTH(8)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b0; in_valid = 1'b1; out_ready = 1'b0; a = 8'd3; b = 8'd4;
    step();
    step();
    ntotal++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
    else npass++;
    ntotal++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
    else npass++;
    ntotal++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else npass++;
    ntotal++;
    if (product !== 16'd0) $display("FAIL reset_product: got %0d want 0", product);
    else npass++;
    in_valid = 1'b0;
    rstN = 1'b1;
    #1;
    ntotal++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready: got %b want 1", in_ready);
    else npass++;
    step();
    ntotal++;
    if (busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset_idle_hold: got busy=%b in_ready=%b want busy=0 in_ready=1", busy, in_ready);
    else npass++;
  endtask

  // One complete operation with out_ready held high.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [15:0] exp, input string name);
    int n;
    a = ta; b = tb_v; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    ntotal++;
    if (busy !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL %s_accept: got busy=%b in_ready=%b want busy=1 in_ready=0", name, busy, in_ready);
    else npass++;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    ntotal++;
    if (n != 8) $display("FAIL %s_latency: got %0d want 8", name, n);
    else npass++;
    ntotal++;
    if (product !== exp) $display("FAIL %s_product: got %0d want %0d", name, product, exp);
    else npass++;
    step();
    ntotal++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s_release: got out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    else npass++;
  endtask

  task automatic test_basic();
    run_op(8'd13, 8'd11, 16'd143, "basic_13x11");
  endtask

  task automatic test_corners();
    logic [7:0]  ca [4];
    logic [7:0]  cb [4];
    logic [15:0] ce [4];
    ca[0] = 8'd255; cb[0] = 8'd255; ce[0] = 16'hFE01;
    ca[1] = 8'd0;   cb[1] = 8'd200; ce[1] = 16'd0;
    ca[2] = 8'd1;   cb[2] = 8'd128; ce[2] = 16'd128;
    ca[3] = 8'd200; cb[3] = 8'd0;   ce[3] = 16'd0;
    for (int i = 0; i < 4; i++) begin
      run_op(ca[i], cb[i], ce[i], $sformatf("corner%0d", i));
    end
  endtask

  task automatic test_backpressure();
    int n;
    a = 8'd7; b = 8'd9; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    ntotal++;
    if (n != 8) $display("FAIL bp_latency: got %0d want 8", n);
    else npass++;
    for (int i = 0; i < 5; i++) begin
      step();
      ntotal++;
      if (out_valid !== 1'b1 || product !== 16'd63 || in_ready !== 1'b0)
        $display("FAIL bp_hold%0d: got out_valid=%b product=%0d in_ready=%b want 1/63/0",
                 i, out_valid, product, in_ready);
      else npass++;
    end
    out_ready = 1'b1;
    step();
    ntotal++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_transfer: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    else npass++;
  endtask

  task automatic test_mid_reset();
    a = 8'd100; b = 8'd3; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rstN = 1'b0;
    step();
    ntotal++;
    if (out_valid !== 1'b0 || product !== 16'd0 || busy !== 1'b0)
      $display("FAIL midrst_clear: got out_valid=%b product=%0d busy=%b want 0/0/0",
               out_valid, product, busy);
    else npass++;
    rstN = 1'b1;
    #1;
    ntotal++;
    if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b want 1", in_ready);
    else npass++;
    run_op(8'd5, 8'd6, 16'd30, "after_abort");
  endtask

  task automatic test_hold_off();
    int n;
    logic ok_hold;
    a = 8'd20; b = 8'd12; in_valid = 1'b1; out_ready = 1'b0;
    step();
    ok_hold = 1'b1;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      a = a + 8'd37; b = b + 8'd5;
      if (in_ready !== 1'b0) ok_hold = 1'b0;
      step();
      n++;
    end
    ntotal++;
    if (n != 8) $display("FAIL holdoff_latency: got %0d want 8", n);
    else npass++;
    ntotal++;
    if (product !== 16'd240) $display("FAIL holdoff_product: got %0d want 240", product);
    else npass++;
    for (int i = 0; i < 2; i++) begin
      a = a + 8'd37; b = b + 8'd5;
      if (in_ready !== 1'b0) ok_hold = 1'b0;
      step();
      ntotal++;
      if (out_valid !== 1'b1 || product !== 16'd240)
        $display("FAIL holdoff_done%0d: got out_valid=%b product=%0d want 1/240", i, out_valid, product);
      else npass++;
    end
    ntotal++;
    if (ok_hold !== 1'b1) $display("FAIL holdoff_in_ready: got in_ready=1 during CALC/DONE want 0");
    else npass++;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    ntotal++;
    if (in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL holdoff_idle: got in_ready=%b busy=%b want 1/0", in_ready, busy);
    else npass++;
    step();
    ntotal++;
    if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL holdoff_no_accept: got busy=%b out_valid=%b want 0/0", busy, out_valid);
    else npass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] expq[$];
    int accepts;
    int results;
    int cyc;
    int last_acc;
    logic acc_now;
    logic [7:0] pa;
    logic [7:0] pb;
    logic [15:0] ev;
    accepts = 0; results = 0; cyc = 0; last_acc = 0;
    out_ready = 1'b1;
    pa = 8'($urandom_range(0, 255)); pb = 8'($urandom_range(0, 255));
    a = pa; b = pb; in_valid = 1'b1;
    while (results < 20 && cyc < 400) begin
      acc_now = in_valid && in_ready;
      step();
      cyc++;
      if (acc_now) begin
        expq.push_back(16'(pa) * 16'(pb));
        if (accepts > 0) begin
          ntotal++;
          if (cyc - last_acc != 10)
            $display("FAIL b2b_spacing%0d: got %0d want 10", accepts, cyc - last_acc);
          else npass++;
        end
        last_acc = cyc;
        accepts++;
        if (accepts == 20) begin
          in_valid = 1'b0;
        end else begin
          pa = 8'($urandom_range(0, 255)); pb = 8'($urandom_range(0, 255));
          a = pa; b = pb;
        end
      end
      if (out_valid === 1'b1) begin
        ev = (expq.size() > 0) ? expq.pop_front() : 16'hxxxx;
        ntotal++;
        if (product !== ev) $display("FAIL b2b_product%0d: got %0d want %0d", results, product, ev);
        else npass++;
        results++;
      end
    end
    in_valid = 1'b0;
    ntotal++;
    if (results != 20) $display("FAIL b2b_count: got %0d want 20", results);
    else npass++;
  endtask

  initial begin
    npass = 0; ntotal = 0;
    rstN = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_mid_reset();
    test_hold_off();
    test_back_to_back();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
